key_debounce: RTL and testbench

KEY_DEBOUNCE -- requirements
Module: key_debounce

---
 rtl/key_debounce.sv | 175 +++++++++++++++++
 tb/tb_key_debounce.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// Debounces four active-low, bouncing board buttons (up/down/left/right).
// Each key has its own two-flop synchronizer, stable-level register, debounce
// counter and IDLE/DEB_PRESS/HELD/DEB_REL state machine; channels never interact.
// A level change is accepted after DEB_CYCLES consecutive differing samples
// (DEB_CYCLES+2 cycles after the pin settles, synchronizer included).
//
// Optional feature: define KEY_REPEAT_EN to add auto-repeat press pulses while
// a key is held (first after REPEAT_DLY cycles, then every REPEAT_PER cycles).
//
// Ports:
//   clk                          system clock
//   rst                          asynchronous active-high reset
//   key_up_n/down_n/left_n/right_n  raw active-low buttons (asynchronous)
//   key_up/down/left/right       debounced active-high levels (registered)
//   press[3:0]                   one-cycle press pulses {up, down, left, right}
// -----------------------------------------------------------------------------
module key_debounce #(
    parameter int unsigned DEB_CYCLES = 500000,
    parameter int unsigned REPEAT_DLY = 25000000,
    parameter int unsigned REPEAT_PER = 5000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_up_n,
    input  logic       key_down_n,
    input  logic       key_left_n,
    input  logic       key_right_n,
    output logic       key_up,
    output logic       key_down,
    output logic       key_left,
    output logic       key_right,
    output logic [3:0] press
);

    localparam int unsigned CW = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] C_TERM = CW'(DEB_CYCLES - 1);

`ifdef KEY_REPEAT_EN
    localparam int unsigned RPT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int unsigned RW      = $clog2(RPT_MAX + 1);
`else
    // Auto-repeat disabled: exactly one pulse per accepted press.
`endif

    // Elaboration-time guard on parameter ranges.
    if (DEB_CYCLES < 2 || REPEAT_DLY < 1 || REPEAT_PER < 1) begin : g_bad_param
        $error("key_debounce: illegal parameter value");
    end

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DEB_PRESS = 2'd1,
        HELD      = 2'd2,
        DEB_REL   = 2'd3
    } state_t;

    logic [3:0] raw_n;
    logic [3:0] level;
    logic [3:0] pulse;

    assign raw_n = {key_up_n, key_down_n, key_left_n, key_right_n};

    for (genvar i = 0; i < 4; i++) begin : g_ch
        logic [1:0]    sync_q;
        logic          sample;
        state_t        state;
        logic [CW-1:0] cnt;
        logic          lvl;
        logic          pls;
`ifdef KEY_REPEAT_EN
        logic [RW-1:0] rpt;
        logic          rpt_first;
        logic [RW-1:0] rpt_term;

        // Terminal count: initial delay first, then the repeat period.
        assign rpt_term = rpt_first ? RW'(REPEAT_DLY - 1) : RW'(REPEAT_PER - 1);
`endif

        // Two-flop synchronizer; resets to the released (high) level.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync_q <= 2'b11;
            end else begin
                sync_q <= {sync_q[0], raw_n[i]};
            end
        end

        assign sample = ~sync_q[1];

        // Debounce state machine; lvl is the stable level S, cnt is C.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state     <= IDLE;
                cnt       <= '0;
                lvl       <= 1'b0;
                pls       <= 1'b0;
`ifdef KEY_REPEAT_EN
                rpt       <= '0;
                rpt_first <= 1'b1;
`endif
            end else begin
                pls <= 1'b0;
                case (state)
                    IDLE: begin
                        if (sample) begin
                            cnt   <= CW'(1);
                            state <= DEB_PRESS;
                        end
                    end
                    DEB_PRESS: begin
                        if (!sample) begin
                            cnt   <= '0;
                            state <= IDLE;
                        end else if (cnt == C_TERM) begin
                            cnt   <= '0;
                            lvl   <= 1'b1;
                            pls   <= 1'b1;
                            state <= HELD;
`ifdef KEY_REPEAT_EN
                            rpt       <= '0;
                            rpt_first <= 1'b1;
`endif
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    HELD: begin
                        if (!sample) begin
                            cnt   <= CW'(1);
                            state <= DEB_REL;
`ifdef KEY_REPEAT_EN
                            rpt       <= '0;
                            rpt_first <= 1'b1;
                        end else if (rpt == rpt_term) begin
                            pls       <= 1'b1;
                            rpt       <= '0;
                            rpt_first <= 1'b0;
                        end else begin
                            rpt <= rpt + RW'(1);
`endif
                        end
                    end
                    DEB_REL: begin
                        if (sample) begin
                            cnt   <= '0;
                            state <= HELD;
                        end else if (cnt == C_TERM) begin
                            cnt   <= '0;
                            lvl   <= 1'b0;
                            state <= IDLE;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    default: begin
                        cnt   <= '0;
                        state <= IDLE;
                    end
                endcase
            end
        end

        assign level[i] = lvl;
        assign pulse[i] = pls;
    end

    assign key_up    = level[3];
    assign key_down  = level[2];
    assign key_left  = level[1];
    assign key_right = level[0];
    assign press     = pulse;

endmodule

// File: tb/tb_key_debounce.sv
// -----------------------------------------------------------------------------
// tb_key_debounce
// Scoreboard bench for key_debounce. A history-based reference model predicts
// every output event (level change or press pulse) with its cycle stamp and
// queues it; a monitor on the falling edge pops and compares whenever the DUT
// shows an event. Directed scenarios plus randomized key activity and resets.
// Honors KEY_REPEAT_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_key_debounce;

    localparam int unsigned DEB  = 8;
    localparam int unsigned RDLY = 20;
    localparam int unsigned RPER = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_up_n = 1'b1, key_down_n = 1'b1, key_left_n = 1'b1, key_right_n = 1'b1;
    logic       key_up, key_down, key_left, key_right;
    logic [3:0] press;

    key_debounce #(
        .DEB_CYCLES(DEB),
        .REPEAT_DLY(RDLY),
        .REPEAT_PER(RPER)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_up_n   (key_up_n),
        .key_down_n (key_down_n),
        .key_left_n (key_left_n),
        .key_right_n(key_right_n),
        .key_up     (key_up),
        .key_down   (key_down),
        .key_left   (key_left),
        .key_right  (key_right),
        .press      (press)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         stamp;
        logic [7:0] vec;
    } ev_t;

    ev_t        exp_q[$];
    int         edge_no = 0;
    int         n_vec   = 0;
    int         n_bad   = 0;

    // Model state: raw history and debouncer-visible samples indexed by edge.
    logic [3:0] rh[$];
    logic [3:0] sq[$];
    int         last_rst = 0;
    logic [3:0] lvl_m    = '0;
    logic [3:0] pr_m     = '0;
    logic [7:0] prev_exp = '0;
    logic [3:0] cur_raw  = '0;
`ifdef KEY_REPEAT_EN
    int         since[4];
    bit         rfirst[4];
`endif

    // Monitor bookkeeping used by directed checks.
    int         press_cnt[4];
    int         last_press[4];
    bit         mon_en   = 1'b0;
    logic [7:0] mon_prev = '0;

    task automatic chk(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, edge_no);
        end
    endtask

    task automatic model_clear();
        lvl_m = '0;
        pr_m  = '0;
`ifdef KEY_REPEAT_EN
        for (int i = 0; i < 4; i++) begin
            since[i]  = 0;
            rfirst[i] = 1'b1;
        end
`endif
    endtask

    // Outputs after clock edge edge_no, from the key histories.
    task automatic model_edge();
        logic [3:0] s;
        logic [3:0] new_l;
        bit         all_diff;
        bit         held_before;
        rh.push_back(~{key_up_n, key_down_n, key_left_n, key_right_n});
        pr_m = '0;
        if (rst) begin
            last_rst = edge_no;
            sq.push_back(4'b0000);
            model_clear();
        end else begin
            for (int i = 0; i < 4; i++)
                s[i] = (edge_no - last_rst >= 3) ? rh[edge_no - 2][i] : 1'b0;
            sq.push_back(s);
            new_l = lvl_m;
            for (int i = 0; i < 4; i++) begin
                // Accept a change after DEB consecutive post-reset samples that disagree.
                all_diff = 1'b1;
                for (int j = 0; j < int'(DEB); j++)
                    if (edge_no - j <= last_rst || sq[edge_no - j][i] == lvl_m[i]) all_diff = 1'b0;
                held_before = lvl_m[i] && (edge_no - 1 > last_rst) && sq[edge_no - 1][i];
                if (all_diff) begin
                    new_l[i] = ~lvl_m[i];
                    if (!lvl_m[i]) pr_m[i] = 1'b1;
                end
`ifdef KEY_REPEAT_EN
                if (!all_diff && held_before && s[i]) begin
                    since[i]++;
                    if (since[i] == (rfirst[i] ? int'(RDLY) : int'(RPER))) begin
                        pr_m[i]   = 1'b1;
                        since[i]  = 0;
                        rfirst[i] = 1'b0;
                    end
                end else begin
                    since[i]  = 0;
                    rfirst[i] = 1'b1;
                end
`else
                if (held_before && s[i]) pr_m[i] = pr_m[i];
`endif
            end
            lvl_m = new_l;
        end
    endtask

    // One clock: model the edge, then drive the next raw/rst values and queue the expectation.
    task automatic cycle(input logic [3:0] raw_act, input logic r);
        ev_t  e;
        logic old_rst;
        @(posedge clk);
        edge_no++;
        model_edge();
        #2;
        old_rst = rst;
        rst     = r;
        cur_raw = raw_act;
        {key_up_n, key_down_n, key_left_n, key_right_n} = ~raw_act;
        if (r && !old_rst) model_clear();
        e.stamp = edge_no;
        e.vec   = {lvl_m, pr_m};
        if (e.vec != prev_exp || pr_m != 4'b0000) exp_q.push_back(e);
        prev_exp = e.vec;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(cur_raw, 1'b0);
    endtask

    task automatic clear_press_stats();
        for (int i = 0; i < 4; i++) begin
            press_cnt[i]  = 0;
            last_press[i] = -1;
        end
    endtask

    // Monitor: pops and compares whenever the DUT presents an event.
    always @(negedge clk) begin
        logic [7:0] vec;
        ev_t        e;
        if (mon_en) begin
            vec = {key_up, key_down, key_left, key_right, press};
            if (exp_q.size() > 0 && exp_q[0].stamp < edge_no) begin
                e = exp_q.pop_front();
                n_vec++;
                n_bad++;
                $display("FAIL missed_event: expected %b at cycle %0d, DUT did not present it", e.vec, e.stamp);
            end
            if (vec != mon_prev || press != 4'b0000) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_event: got %b at cycle %0d, expected none", vec, edge_no);
                end else begin
                    e = exp_q.pop_front();
                    if (e.stamp != edge_no || e.vec != vec) begin
                        n_bad++;
                        $display("FAIL event: got %b at cycle %0d, expected %b at cycle %0d",
                                 vec, edge_no, e.vec, e.stamp);
                    end
                end
                for (int i = 0; i < 4; i++)
                    if (press[i]) begin
                        press_cnt[i]++;
                        last_press[i] = edge_no;
                    end
            end
            mon_prev = vec;
        end
    end

    initial begin
        int s;
        int hold[4];
        logic [3:0] rnd_raw;
        rh.push_back(4'b0000);
        sq.push_back(4'b0000);
        clear_press_stats();

        #3;
        chk("reset_outputs", int'({key_up, key_down, key_left, key_right, press}), 0);
        mon_en = 1'b1;
        cycle(4'b0000, 1'b1);
        cycle(4'b0000, 1'b1);
        cycle(4'b0000, 1'b0);
        idle(5);

        // Clean press of up.
        clear_press_stats();
        cycle(4'b1000, 1'b0);
        s = edge_no;
        idle(20);
        chk("clean_press_count", press_cnt[3], 1);
        chk("clean_press_cycle", last_press[3] - s, 10);
        cycle(4'b0000, 1'b0);
        idle(15);

        // Bounce on left: toggles every 3 cycles for 30 cycles, then released.
        clear_press_stats();
        for (int k = 0; k < 10; k++) begin
            cycle((k % 2 == 0) ? 4'b0010 : 4'b0000, 1'b0);
            idle(2);
        end
        cycle(4'b0000, 1'b0);
        idle(15);
        chk("bounce_no_press", press_cnt[1], 0);

        // Simultaneous down + right, then release down alone.
        clear_press_stats();
        cycle(4'b0101, 1'b0);
        s = edge_no;
        idle(39);
        cycle(4'b0001, 1'b0);
        idle(20);
        chk("simul_down_cycle", last_press[2] - s, 10);
        chk("simul_right_cycle", last_press[0] - s, 10);
        chk("simul_down_count", press_cnt[2], 1);
        chk("simul_right_level", int'(key_right), 1);
        chk("simul_down_level", int'(key_down), 0);
        cycle(4'b0000, 1'b0);
        idle(15);

        // Reset mid-debounce.
        clear_press_stats();
        cycle(4'b1000, 1'b0);
        s = edge_no;
        idle(4);
        cycle(4'b1000, 1'b1);
        cycle(4'b1000, 1'b1);
        cycle(4'b1000, 1'b0);
        idle(20);
        chk("rstmid_press_count", press_cnt[3], 1);
        chk("rstmid_press_cycle", last_press[3] - s, 17);
        cycle(4'b0000, 1'b0);
        idle(15);

        // Long hold of up (auto-repeat when enabled).
        clear_press_stats();
        cycle(4'b1000, 1'b0);
        s = edge_no;
        idle(64);
        cycle(4'b0000, 1'b0);
        idle(30);
`ifdef KEY_REPEAT_EN
        chk("hold_press_count", press_cnt[3], 9);
        chk("hold_last_press", last_press[3] - s, 65);
`else
        chk("hold_press_count", press_cnt[3], 1);
        chk("hold_last_press", last_press[3] - s, 10);
`endif

        // Randomized activity on all keys with occasional resets.
        for (int i = 0; i < 4; i++) hold[i] = 0;
        rnd_raw = '0;
        for (int k = 0; k < 2000; k++) begin
            for (int i = 0; i < 4; i++) begin
                if (hold[i] == 0) begin
                    rnd_raw[i] = ~rnd_raw[i];
                    hold[i]    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 60))
                                                             : int'($urandom_range(1, 2 * DEB + 2));
                end else begin
                    hold[i]--;
                end
            end
            cycle(rnd_raw, ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0);
        end
        cycle(4'b0000, 1'b0);
        idle(40);
        chk("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
